sqrt_sequencer: RTL and testbench
=================================

SQRT_SEQUENCER -- requirements
Module: sqrt_sequencer

Interface
REQ-001 Parameter ITERS, default 8, sets the maximum Newton iterations per operand (1..15).
REQ-002 Parameter DIV_TIMEOUT, default 64, sets the maximum cycles to wait for div_done (>=2).
REQ-003 Port clk, input, 1: single clock; all state is updated on the posedge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1: operand A is valid.
REQ-006 Port in_ready, output, 1: the sequencer accepts an operand.
REQ-007 Port in_a, input, 32: IEEE-754 single-precision operand A.
REQ-008 Port div_start, output, 1: one-cycle pulse that launches the external fp_divider.
REQ-009 Port div_num and div_den, output, 32 each: divider numerator (A) and denominator (current estimate).
REQ-010 Port div_done, input, 1: divider quotient is valid this cycle.
REQ-011 Port div_q, input, 32: divider quotient.
REQ-012 Port add_a and add_b, output, 32 each: operands of the external combinational fp_adder.
REQ-013 Port add_sum, input, 32: fp_adder result.
REQ-014 Port out_valid, output, 1: the result is valid.
REQ-015 Port out_ready, input, 1: the consumer accepts the result.
REQ-016 Port out_root, output, 32: the square-root result.
REQ-017 Port out_err, output, 1: divider timeout occurred; qualified by out_valid.

Function
REQ-018 The state machine SHALL use the states IDLE, DIV_WAIT, UPDATE and DONE.
REQ-019 In IDLE, in_ready=1; on in_valid&in_ready, A SHALL be latched into a_reg.
REQ-020 On acceptance in IDLE, the special cases SHALL take IDLE->DONE with no div_start:
- zero (either sign) -> result A;
- sign=1 and nonzero, or NaN -> 0x7FC00000;
- +Inf -> 0x7F800000.
REQ-021 For any other operand, acceptance SHALL set est=0x3F800000 and iter=0, pulse div_start in the next cycle, and go to DIV_WAIT.
REQ-022 div_num=a_reg and div_den=est SHALL be held stable from the div_start pulse until div_done.
REQ-023 In DIV_WAIT, div_done SHALL capture div_q into q_reg and go to UPDATE.
REQ-024 If div_done is absent after DIV_TIMEOUT cycles, the block SHALL go to DONE with out_err=1 and out_root=est.
REQ-025 In UPDATE, add_a=q_reg and add_b=est; next est = {add_sum[31], add_sum[30:23]-1, add_sum[22:0]}, except that an exponent of 0 SHALL stay 0 (no wrap).
REQ-026 UPDATE SHALL go to DONE if next est equals est (converged) or iter+1==ITERS; otherwise it SHALL increment iter, pulse div_start and return to DIV_WAIT.
REQ-027 In DONE, out_valid=1 and out_root/out_err SHALL be held stable until out_ready=1, then the block SHALL return to IDLE (in_ready=1 in the following cycle).
REQ-028 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE SHALL be ignored.
REQ-029 div_done outside DIV_WAIT SHALL be ignored.
REQ-030 Latency for a normal operand SHALL be 1 + sum over iterations of (divider latency + 2) cycles from acceptance to out_valid.

Reset
REQ-031 rst_n=0 SHALL immediately force the state machine to IDLE regardless of the current state, including mid-operation, and the outputs to:
- in_ready=0 while rst_n=0;
- div_start=0, out_valid=0, out_err=0;
- out_root=0, est=0x3F800000, iter=0.
REQ-032 in_ready SHALL rise in the first clk edge after rst_n deasserts.
REQ-033 A divider completion arriving after reset SHALL be ignored.

Structure
REQ-034 The FSM state enum, the constants FP_ONE=0x3F800000, FP_QNAN=0x7FC00000 and FP_PINF=0x7F800000, and the FP field-slice helpers SHALL live in shared package fp_pkg.
REQ-035 The IEEE special-case classifier SHALL be one sub-module, fp_classify (zero/neg/nan/inf flags).
REQ-036 fp_divider and fp_adder SHALL stay external and be instantiated beside the sequencer.

Verification
REQ-037 With a 3-cycle divider model, A=0x40800000 (4.0) -> out_root=0x40000000 within ITERS iterations, out_err=0.
REQ-038 A=0x00000000 -> out_valid 2 cycles after acceptance, out_root=0x00000000, no div_start seen.
REQ-039 A=0xC0800000 (-4.0) -> out_root=0x7FC00000, no div_start seen.
REQ-040 A divider model that never asserts div_done -> out_valid after DIV_TIMEOUT cycles with out_err=1 and out_root=0x3F800000.
REQ-041 Holding out_ready=0 for 10 cycles in DONE -> out_valid and out_root stable; in_ready=0 throughout.
REQ-042 rst_n pulsed low during DIV_WAIT, then a late div_done -> block returns to IDLE, out_valid stays 0, and the next A=0x41100000 (9.0) yields 0x40400000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the square-root sequencer: FSM states, IEEE-754
// single-precision constants and field-slice helpers.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    UPDATE   = 2'd2,
    DONE     = 2'd3
  } sq_state_e;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;

  function automatic logic fp_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [22:0] fp_man(input logic [31:0] f);
    return f[22:0];
  endfunction

  // Divide by two by decrementing the exponent; a zero exponent is left
  // untouched so that tiny values never wrap to a huge exponent.
  function automatic logic [31:0] fp_half(input logic [31:0] f);
    logic [7:0] e;
    e = fp_exp(f);
    if (e != 8'd0) begin
      e = e - 8'd1;
    end
    return {fp_sign(f), e, fp_man(f)};
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier: zero, negative,
// NaN and infinity flags for one operand.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] f_i,
  output logic        zero_o,
  output logic        neg_o,
  output logic        nan_o,
  output logic        inf_o
);

  logic exp_zero;
  logic exp_ones;
  logic man_zero;

  assign exp_zero = (fp_exp(f_i) == 8'h00);
  assign exp_ones = (fp_exp(f_i) == 8'hFF);
  assign man_zero = (fp_man(f_i) == 23'd0);

  assign zero_o = exp_zero && man_zero;
  assign neg_o  = fp_sign(f_i);
  assign nan_o  = exp_ones && !man_zero;
  assign inf_o  = exp_ones && man_zero;

endmodule

// File: rtl/sqrt_sequencer.sv
// Newton-Raphson square-root sequencer. Drives an external fp_divider
// (A / est) and an external combinational fp_adder (q + est), halving the
// sum to form the next estimate until it converges or ITERS is reached.
module sqrt_sequencer
  import fp_pkg::*;
#(
  parameter int ITERS       = 8,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  output logic        div_start,
  output logic [31:0] div_num,
  output logic [31:0] div_den,
  input  logic        div_done,
  input  logic [31:0] div_q,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_root,
  output logic        out_err
);

  localparam int TW = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(DIV_TIMEOUT - 1);
  localparam logic [3:0]    ITER_LAST = 4'(ITERS);

  sq_state_e     state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          div_start_q, div_start_d;
  logic [31:0]   est_q, est_d;
  logic [3:0]    iter_q, iter_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   out_root_q, out_root_d;
  logic          out_err_q, out_err_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   q_q, q_d;

  logic          cls_zero, cls_neg, cls_nan, cls_inf;
  logic [31:0]   est_next;
  logic          accept;

  // Special cases are decided on the operand as it is accepted.
  fp_classify u_classify (
    .f_i    (in_a),
    .zero_o (cls_zero),
    .neg_o  (cls_neg),
    .nan_o  (cls_nan),
    .inf_o  (cls_inf)
  );

  assign accept   = in_valid && in_ready_q;
  assign est_next = fp_half(add_sum);

  // Next-state and register-update logic for the Newton sequencer.
  always_comb begin
    state_d     = state_q;
    est_d       = est_q;
    iter_d      = iter_q;
    tmo_d       = tmo_q;
    div_start_d = 1'b0;
    out_root_d  = out_root_q;
    out_err_d   = out_err_q;
    a_d         = a_q;
    q_d         = q_q;
    in_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d       = in_a;
          out_err_d = 1'b0;
          if (cls_zero) begin
            out_root_d = in_a;
            state_d    = DONE;
          end else if (cls_nan || cls_neg) begin
            out_root_d = FP_QNAN;
            state_d    = DONE;
          end else if (cls_inf) begin
            out_root_d = FP_PINF;
            state_d    = DONE;
          end else begin
            est_d       = FP_ONE;
            iter_d      = 4'd0;
            tmo_d       = '0;
            div_start_d = 1'b1;
            state_d     = DIV_WAIT;
          end
        end
      end

      DIV_WAIT: begin
        if (div_done) begin
          q_d     = div_q;
          state_d = UPDATE;
        end else if (tmo_q == TMO_LAST) begin
          out_err_d  = 1'b1;
          out_root_d = est_q;
          state_d    = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      UPDATE: begin
        est_d = est_next;
        if ((est_next == est_q) || ((iter_q + 4'd1) == ITER_LAST)) begin
          out_root_d = est_next;
          state_d    = DONE;
        end else begin
          iter_d      = iter_q + 4'd1;
          tmo_d       = '0;
          div_start_d = 1'b1;
          state_d     = DIV_WAIT;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // Control and result registers; reset returns everything to an idle,
  // not-yet-ready condition so in_ready rises on the first edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      div_start_q <= 1'b0;
      est_q       <= FP_ONE;
      iter_q      <= 4'd0;
      tmo_q       <= '0;
      out_root_q  <= 32'd0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      div_start_q <= div_start_d;
      est_q       <= est_d;
      iter_q      <= iter_d;
      tmo_q       <= tmo_d;
      out_root_q  <= out_root_d;
      out_err_q   <= out_err_d;
    end
  end

  // Operand and quotient holding registers; only read in states that
  // are entered after they have been loaded, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    q_q <= q_d;
  end

  assign in_ready  = in_ready_q;
  assign div_start = div_start_q;
  assign div_num   = a_q;
  assign div_den   = est_q;
  assign add_a     = q_q;
  assign add_b     = est_q;
  assign out_valid = (state_q == DONE);
  assign out_root  = out_root_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Self-checking bench for sqrt_sequencer with behavioural fp_divider and
// fp_adder models built on real arithmetic rounded to single precision.
module tb_sqrt_sequencer;

  localparam int ITERS       = 8;
  localparam int DIV_TIMEOUT = 64;
  localparam int DIV_LAT     = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic        div_start;
  logic [31:0] div_num;
  logic [31:0] div_den;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_root;
  logic        out_err;

  int nvec = 0;
  int nerr = 0;
  int ds_cnt = 0;

  always #5 clk = ~clk;

  sqrt_sequencer #(.ITERS(ITERS), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .div_start (div_start),
    .div_num   (div_num),
    .div_den   (div_den),
    .div_done  (div_done),
    .div_q     (div_q),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_root  (out_root),
    .out_err   (out_err)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    int e;
    if (f[30:23] == 8'd0) return 0.0;
    e = int'(f[30:23]) - 127 + 1023;
    b = {f[31], 11'(e), f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int e;
    logic [24:0] m;
    b = $realtobits(r);
    if (b[62:52] == 11'd0) return {b[63], 31'd0};
    e = int'(b[62:52]) - 1023 + 127;
    m = {2'b01, b[51:29]};
    if (b[28] && ((|b[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e <= 0) return {b[63], 31'd0};
    if (e >= 255) return {b[63], 8'hFF, 23'd0};
    return {b[63], 8'(e), m[22:0]};
  endfunction

  // Divider model: quotient valid DIV_LAT cycles after the start pulse;
  // not reset, so an in-flight operation can finish after a DUT reset.
  bit          div_never = 1'b0;
  int          dcnt = 0;
  logic [31:0] dq = 32'd0;
  always @(posedge clk) begin
    if (div_start && !div_never) begin
      dcnt <= DIV_LAT;
      dq   <= r2f(f2r(div_num) / f2r(div_den));
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_done = (dcnt == 1);
  assign div_q    = dq;

  assign add_sum = r2f(f2r(add_a) + f2r(add_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  typedef struct packed {
    logic [31:0] root;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t sb_e;

  // Scoreboard pop on every output handshake; also counts divider launches.
  always @(negedge clk) begin
    if (div_start) ds_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL sb_unexpected_output: got %h expected none", out_root);
      end else begin
        sb_e = sb.pop_front();
        chk("out_root", out_root, sb_e.root);
        chk("out_err", {31'd0, out_err}, {31'd0, sb_e.err});
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic push,
                      input logic [31:0] er, input logic ee);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_a     = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (push) sb.push_back('{root: er, err: ee});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cyc = i;
        return;
      end
    end
    chk("out_valid_timeout", 32'd0, 32'd1);
    cyc = -1;
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] root;
    logic        err;
    logic        nodiv;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ds0;
    tbl[0]  = '{a: 32'h0000_0000, root: 32'h0000_0000, err: 1'b0, nodiv: 1'b1};
    tbl[1]  = '{a: 32'h8000_0000, root: 32'h8000_0000, err: 1'b0, nodiv: 1'b1};
    tbl[2]  = '{a: 32'hC080_0000, root: 32'h7FC0_0000, err: 1'b0, nodiv: 1'b1};
    tbl[3]  = '{a: 32'h7FC0_0000, root: 32'h7FC0_0000, err: 1'b0, nodiv: 1'b1};
    tbl[4]  = '{a: 32'h7F80_0001, root: 32'h7FC0_0000, err: 1'b0, nodiv: 1'b1};
    tbl[5]  = '{a: 32'h7F80_0000, root: 32'h7F80_0000, err: 1'b0, nodiv: 1'b1};
    tbl[6]  = '{a: 32'hFF80_0000, root: 32'h7FC0_0000, err: 1'b0, nodiv: 1'b1};
    tbl[7]  = '{a: 32'h8000_0001, root: 32'h7FC0_0000, err: 1'b0, nodiv: 1'b1};
    tbl[8]  = '{a: 32'h4080_0000, root: 32'h4000_0000, err: 1'b0, nodiv: 1'b0};
    tbl[9]  = '{a: 32'h4110_0000, root: 32'h4040_0000, err: 1'b0, nodiv: 1'b0};
    tbl[10] = '{a: 32'h3E80_0000, root: 32'h3F00_0000, err: 1'b0, nodiv: 1'b0};
    tbl[11] = '{a: 32'h4010_0000, root: 32'h3FC0_0000, err: 1'b0, nodiv: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_div_start", {31'd0, div_start}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_out_root", out_root, 32'd0);
    chk("rst_div_den", div_den, 32'h3F80_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("rel_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Table of operands: special cases and normal Newton convergence.
    for (int i = 0; i < 12; i++) begin
      ds0 = ds_cnt;
      send(tbl[i].a, 1'b1, tbl[i].root, tbl[i].err);
      wait_out(cyc);
      if (tbl[i].nodiv) begin
        chk("special_latency_le2", {31'd0, (cyc >= 1 && cyc <= 2)}, 32'd1);
      end
      @(posedge clk); #1;
      if (tbl[i].nodiv) chk("no_div_start", ds_cnt - ds0, 32'd0);
      else chk("div_started", {31'd0, (ds_cnt > ds0)}, 32'd1);
    end

    // Single-iteration operand: latency is 1 + (divider latency + 2).
    send(32'h3F80_0000, 1'b1, 32'h3F80_0000, 1'b0);
    wait_out(cyc);
    chk("latency_one_iter", cyc, 32'(1 + DIV_LAT + 2));
    @(posedge clk); #1;

    // Divider never answers: timeout with the initial estimate.
    div_never = 1'b1;
    send(32'h4080_0000, 1'b1, 32'h3F80_0000, 1'b1);
    wait_out(cyc);
    chk("timeout_latency", {31'd0, (cyc >= DIV_TIMEOUT && cyc <= DIV_TIMEOUT + 2)}, 32'd1);
    @(posedge clk); #1;
    div_never = 1'b0;

    // Back-pressure: result held stable while out_ready is low.
    out_ready = 1'b0;
    send(32'h4080_0000, 1'b1, 32'h4000_0000, 1'b0);
    wait_out(cyc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_root", out_root, 32'h4000_0000);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("after_done_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in DIV_WAIT, late divider completion must be ignored.
    send(32'h4080_0000, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("mid_div_start", {31'd0, div_start}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_div_start", {31'd0, div_start}, 32'd0);
    chk("mid_rst_out_root", out_root, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready_0", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("mid_rel_in_ready_1", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("late_done_no_out", {31'd0, out_valid}, 32'd0);
    end
    send(32'h4110_0000, 1'b1, 32'h4040_0000, 1'b0);
    wait_out(cyc);
    @(posedge clk); #1;
    @(negedge clk);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
